// File: rtl/sound_tone_gen.sv
// sound_tone_gen: turns a 4-bit note index into a square wave with a linear
// attack/release volume envelope. Produces a signed 16-bit PCM sample on a
// fixed-rate strobe plus a raw 1-bit square wave for a speaker pin.
//
// Output protocol: sample_valid is a one-clock strobe with no back-pressure;
// sample changes only in the strobe cycle and holds its value between strobes.
//
// DIV_SHIFT right-shifts every half-period from the note ROM. It is 0 for the
// real 50 MHz pitch table; a non-zero value only shortens simulations.
module sound_tone_gen #(
  parameter int ENV_STEP   = 50000,
  parameter int SAMPLE_DIV = 1042,
  parameter int AMP        = 2048,
  parameter int DIV_SHIFT  = 0
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               enable_sound,
  input  logic [3:0]         freq,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  output logic               square_out,
  output logic               busy
);

  localparam int ENV_W  = (ENV_STEP > 1)   ? $clog2(ENV_STEP)   : 1;
  localparam int SAMP_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [ENV_W-1:0]  ENV_LAST  = ENV_W'(ENV_STEP - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t            state, state_next;
  logic [3:0]        volume, vol_next;
  logic [ENV_W-1:0]  env_cnt, env_next;
  logic [16:0]       half_cnt, half_next, half_last;
  logic              phase, phase_next;
  logic [3:0]        note_reg, note_next;
  logic [SAMP_W-1:0] samp_cnt;
  logic              note_req, env_wrap, samp_wrap;
  logic [15:0]       mag;

  // Half-period in clocks for C4..C6 diatonic; index 0 is never loaded.
  function automatic logic [16:0] half_period(input logic [3:0] idx);
    logic [16:0] p;
    case (idx)
      4'd1:    p = 17'd95556;
      4'd2:    p = 17'd85131;
      4'd3:    p = 17'd75843;
      4'd4:    p = 17'd71586;
      4'd5:    p = 17'd63776;
      4'd6:    p = 17'd56818;
      4'd7:    p = 17'd50619;
      4'd8:    p = 17'd47778;
      4'd9:    p = 17'd42566;
      4'd10:   p = 17'd37922;
      4'd11:   p = 17'd35793;
      4'd12:   p = 17'd31888;
      4'd13:   p = 17'd28409;
      4'd14:   p = 17'd25310;
      default: p = 17'd23889;
    endcase
    return p >> DIV_SHIFT;
  endfunction

  assign note_req  = enable_sound && (freq != 4'd0);
  assign env_wrap  = (env_cnt == ENV_LAST);
  assign samp_wrap = (samp_cnt == SAMP_LAST);
  assign half_last = half_period(note_reg) - 17'd1;
  assign busy      = (state != IDLE);
  // Magnitude of the sample that goes out with the next strobe (fits in 15 bits).
  assign mag       = 16'(vol_next) * 16'(AMP);

  // Next-state logic: envelope FSM first, then the tone counter, which needs
  // to know whether the FSM is about to enter IDLE.
  always_comb begin
    state_next = state;
    vol_next   = volume;
    env_next   = env_cnt;
    half_next  = half_cnt;
    phase_next = phase;
    note_next  = note_reg;

    case (state)
      IDLE: begin
        if (note_req) begin
          state_next = ATTACK;
          env_next   = '0;
        end
      end
      ATTACK: begin
        env_next = env_wrap ? '0 : env_cnt + ENV_W'(1);
        if (env_wrap && (volume != 4'd15)) vol_next = volume + 4'd1;
        // Losing the request wins over reaching full volume.
        if (!note_req) begin
          state_next = RELEASE;
        end else if (vol_next == 4'd15) begin
          state_next = SUSTAIN;
          env_next   = '0;
        end
      end
      SUSTAIN: begin
        vol_next = 4'd15;
        env_next = '0;
        if (!note_req) state_next = RELEASE;
      end
      RELEASE: begin
        env_next = env_wrap ? '0 : env_cnt + ENV_W'(1);
        if (env_wrap && (volume != 4'd0)) vol_next = volume - 4'd1;
        // A fresh request resumes the attack from the current volume.
        if (note_req) begin
          state_next = ATTACK;
        end else if (vol_next == 4'd0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Pitch only changes on a phase edge so the waveform never glitches.
    if (state_next == IDLE) begin
      half_next  = '0;
      phase_next = 1'b0;
    end else if (state == IDLE) begin
      note_next  = freq;
      half_next  = '0;
      phase_next = 1'b1;
    end else if (half_cnt == half_last) begin
      half_next  = '0;
      phase_next = ~phase;
      if (freq != 4'd0) note_next = freq;
    end else begin
      half_next = half_cnt + 17'd1;
    end
  end

  // Envelope/tone state registers and the registered speaker output.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      volume     <= 4'd0;
      env_cnt    <= '0;
      half_cnt   <= '0;
      phase      <= 1'b0;
      note_reg   <= 4'd0;
      square_out <= 1'b0;
    end else begin
      state      <= state_next;
      volume     <= vol_next;
      env_cnt    <= env_next;
      half_cnt   <= half_next;
      phase      <= phase_next;
      note_reg   <= note_next;
      square_out <= phase_next && (vol_next != 4'd0);
    end
  end

  // Free-running sample-rate divider; the strobe cycle also loads the sample.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      samp_cnt     <= '0;
      sample_valid <= 1'b0;
      sample       <= '0;
    end else begin
      sample_valid <= samp_wrap;
      samp_cnt     <= samp_wrap ? '0 : samp_cnt + SAMP_W'(1);
      if (samp_wrap) sample <= phase_next ? mag : (~mag + 16'd1);
    end
  end

endmodule

// File: doc/sound_tone_gen.md
Name: sound_tone_gen

Overview:
- Downstream consumer of the sound selector's freq[3:0] / enable_sound pair.
- Converts the 4-bit note index into an audible square wave with a linear attack/release volume envelope.
- Emits a 16-bit signed PCM sample with a sample-rate strobe for the audio codec interface, plus a 1-bit square_out for a direct speaker pin.
- Upstream holds freq and enable_sound stable for the note duration (~1 s); this block is responsible for everything audible.

Parameters:
- ENV_STEP, 50000, clocks per one-step volume change (1 ms at 50 MHz).
- SAMPLE_DIV, 1042, clocks per sample_valid strobe (~48 kHz at 50 MHz).
- AMP, 2048, sample amplitude per volume step; AMP*15 must be ≤ 32767.

Ports:
- clk  input  1  system clock, 50 MHz.
- resetN  input  1  asynchronous active-low reset.
- enable_sound  input  1  note request from the sound selector.
- freq  input  4  note index; 0 means silence.
- sample  output  16  signed PCM sample, registered.
- sample_valid  output  1  one-clock strobe; sample is updated in the same cycle.
- square_out  output  1  raw square wave; forced 0 when volume = 0.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async, resetN = 0):
  - sample = 0, sample_valid = 0, square_out = 0, busy = 0.
  - state = IDLE, volume = 0, phase = 0, all counters = 0, note_reg = 0.
- Half-period ROM (clocks, 50 MHz), index 1..15: 95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778, 42566, 37922, 35793, 31888, 28409, 25310, 23889 (C4..C6 diatonic). Index 0 is never loaded.
- Tone counter:
  - half_cnt counts 0..div-1, where div = ROM[note_reg].
  - At div-1: phase toggles, half_cnt returns to 0, and note_reg reloads from freq if freq ≠ 0.
  - A frequency change therefore takes effect only on a phase edge (glitch-free).
  - In IDLE: half_cnt = 0 and phase = 0.
- note request = enable_sound && freq ≠ 0.
- State machine (IDLE / ATTACK / SUSTAIN / RELEASE):
  - IDLE: on a note request, go to ATTACK next clock and set note_reg = freq, half_cnt = 0, phase = 1, env_cnt = 0.
  - ATTACK:
    - env_cnt counts 0..ENV_STEP-1; at the wrap, volume += 1.
    - When volume becomes 15, go to SUSTAIN.
    - Loss of the note request goes to RELEASE and keeps the current volume and env_cnt.
  - SUSTAIN: volume = 15; loss of the note request goes to RELEASE.
  - RELEASE:
    - Volume -= 1 at each env_cnt wrap.
    - When volume becomes 0, go to IDLE.
    - A note request returns to ATTACK from the current volume without restarting phase. The new freq is applied at the next phase edge.
  - Note request and env wrap in the same cycle: the state change wins and the volume step still applies in the current direction.
- Volume:
  - Saturates at 0 and 15; never wraps.
  - Full attack = 15*ENV_STEP clocks; full release = 15*ENV_STEP clocks.
- Sample path:
  - samp_cnt is free-running 0..SAMPLE_DIV-1 from reset.
  - At SAMPLE_DIV-1: sample_valid = 1 for one clock, and sample is updated in the same cycle:
    - phase = 1: sample = +(volume*AMP).
    - phase = 0: sample = −(volume*AMP).
    - volume = 0: sample = 0.
  - Width: the 15-bit unsigned product is zero-extended, then negated in 16-bit two's complement.
  - sample holds its value between strobes.
- square_out = phase && (volume ≠ 0), registered.
- busy goes low on the same clock state enters IDLE.

Test Plan:
- Reset: assert resetN = 0 mid-sustain with freq = 6 → all outputs 0 immediately (async); busy = 0; after release, nothing happens until a new request.
- Attack (ENV_STEP = 4, SAMPLE_DIV = 8, AMP = 2048), enable_sound = 1, freq = 15:
  - busy = 1 one clock later.
  - volume = 15 and SUSTAIN after 60 clocks.
  - Strobed sample = +30720 while phase = 1.
  - square_out toggles every 23889 clocks; the sample becomes −30720 after the first toggle.
- Release: drop enable_sound in SUSTAIN → volume falls by 1 every 4 clocks; sample magnitude steps down by 2048 per step; busy = 0 after 60 clocks; subsequent samples = 0.
- Mid-note retune: freq 15→1 at half_cnt = 100 → current half-period still ends at 23889 clocks; the following half-period lasts 95556 clocks.
- Attack interrupt / re-trigger:
  - Drop enable_sound at volume = 5 → RELEASE; IDLE after 20 clocks.
  - Repeat, but reassert at volume = 3 → ATTACK resumes from 3; 15 is reached 48 clocks later and phase is not reset.
- Silence index: enable_sound = 1 with freq = 0 from IDLE → stays IDLE, sample = 0, busy = 0. freq set to 0 during SUSTAIN → RELEASE exactly as if enable_sound dropped.
